// File: rtl/mpram_counter.sv
// mpram_counter: multiport register file with register 0 acting as an
// up/down wrap counter and an equality flag against register CMP_IDX.
// Optional build macro MPRAM_BYPASS_EN enables write-through forwarding
// for port reads; without it reads always return the stored value.
module mpram_counter #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int NPORTS  = 4,
  parameter int CMP_IDX = DEPTH - 1,
  localparam int AW     = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       port_en,
  input  logic [NPORTS-1:0]       port_we,
  input  logic [NPORTS-1:0]       port_re,
  input  logic [NPORTS*AW-1:0]    port_addr,
  input  logic [NPORTS*WIDTH-1:0] port_wdata,
  output logic [NPORTS*WIDTH-1:0] port_rdata,
  input  logic                    cnt_inc,
  input  logic                    cnt_dec,
  output logic                    cnt_co,
  output logic                    wr_conflict,
  output logic                    eq
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]  regs_q   [DEPTH];
  logic [WIDTH-1:0]  regs_d   [DEPTH];
  logic [AW-1:0]     addr_a   [NPORTS];
  logic [WIDTH-1:0]  wdata_a  [NPORTS];
  logic [NPORTS-1:0] wr_act;
  logic [NPORTS-1:0] rd_act;
  logic [DEPTH-1:0]  wr_hit;
  logic [WIDTH-1:0]  wr_val   [DEPTH];
  logic              cnt_co_d;
  logic              cnt_co_q;
  logic              wr_conflict_d;
  logic              wr_conflict_q;

  // One counter step: returns {wrap, next value}; wrap marks all-ones->0 going
  // up or 0->all-ones going down.
  function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] v,
                                                input logic up);
    logic [WIDTH:0] r;
    if (up) r = {(&v), v + 1'b1};
    else    r = {(~|v), v - 1'b1};
    return r;
  endfunction

  // Unpack the flat port buses and qualify each access with enable and range.
  always_comb begin
    wr_act = '0;
    rd_act = '0;
    for (int p = 0; p < NPORTS; p++) begin
      addr_a[p]  = port_addr[p*AW +: AW];
      wdata_a[p] = port_wdata[p*WIDTH +: WIDTH];
      wr_act[p]  = port_en[p] & port_we[p] & ({1'b0, addr_a[p]} < DEPTH_W);
      rd_act[p]  = port_en[p] & port_re[p] & ({1'b0, addr_a[p]} < DEPTH_W);
    end
  end

  // Resolve writes per register: the lowest-numbered port wins, any extra
  // writer to the same register raises a conflict.
  always_comb begin
    wr_hit        = '0;
    wr_conflict_d = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_act[p] && (addr_a[p] == AW'(r))) begin
          if (wr_hit[r]) begin
            wr_conflict_d = 1'b1;
          end else begin
            wr_hit[r] = 1'b1;
            wr_val[r] = wdata_a[p];
          end
        end
      end
    end
  end

  // Next register state; a port write to register 0 takes precedence over
  // counting and suppresses the wrap pulse.
  always_comb begin
    logic [WIDTH:0] step;
    step     = '0;
    cnt_co_d = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
    end
    if (!wr_hit[0] && (cnt_inc ^ cnt_dec)) begin
      step      = count_step(regs_q[0], cnt_inc);
      regs_d[0] = step[WIDTH-1:0];
      cnt_co_d  = step[WIDTH];
    end
  end

  // Combinational read ports; disabled or out-of-range reads return zero.
  always_comb begin
    port_rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (rd_act[p]) begin
`ifdef MPRAM_BYPASS_EN
        port_rdata[p*WIDTH +: WIDTH] = wr_hit[addr_a[p]] ? wr_val[addr_a[p]]
                                                         : regs_q[addr_a[p]];
`else
        port_rdata[p*WIDTH +: WIDTH] = regs_q[addr_a[p]];
`endif
      end
    end
  end

  // State registers with synchronous reset overriding all requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      cnt_co_q      <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      cnt_co_q      <= cnt_co_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign cnt_co      = cnt_co_q;
  assign wr_conflict = wr_conflict_q;
  assign eq          = (regs_q[0] == regs_q[CMP_IDX]);

endmodule

// File: doc/mpram_counter.md
Name: mpram_counter

Overview:
Parametrised multiport register file with a built-in counter register.
- NPORTS independent read/write ports access DEPTH registers of WIDTH bits.
- Register 0 is an up/down counter; an equality flag compares register 0 against a selectable register.
- Used as a microsequencer loop counter and scratch register bank in the control unit.
- Everything is synchronous to one rising clock edge.

Parameters:
- WIDTH, 4, register and data width in bits (>=1)
- DEPTH, 4, number of registers (>=2); AW = max(1, $clog2(DEPTH))
- NPORTS, 4, number of access ports (>=1)
- CMP_IDX, DEPTH-1, index of the register compared against register 0 for eq

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous active-high reset
- port_en  in  NPORTS  per-port enable; bit p gates port p
- port_we  in  NPORTS  per-port write request (effective only with port_en)
- port_re  in  NPORTS  per-port read request (effective only with port_en)
- port_addr  in  NPORTS*AW  port p address in bits [p*AW +: AW]
- port_wdata  in  NPORTS*WIDTH  port p write data in bits [p*WIDTH +: WIDTH]
- port_rdata  out  NPORTS*WIDTH  port p read data in bits [p*WIDTH +: WIDTH]
- cnt_inc  in  1  increment register 0 this cycle
- cnt_dec  in  1  decrement register 0 this cycle
- cnt_co  out  1  registered wrap pulse from register 0
- wr_conflict  out  1  registered pulse: two or more ports wrote the same register last cycle
- eq  out  1  combinational flag, reg[0] == reg[CMP_IDX]

Behaviour:
Reset:
- reset=1 at a rising edge clears all registers to 0 and sets cnt_co=0, wr_conflict=0.
- eq=1 after reset.
- Reset overrides every write and count request in the same cycle.

Write:
- Port p writes when port_en[p] & port_we[p] and its address is < DEPTH.
- Addresses >= DEPTH: write ignored.
- Write takes effect at the rising edge; the new value is visible from the next cycle.

Write conflict:
- Several ports writing one register in one cycle: the lowest-numbered port wins.
- wr_conflict=1 in the following cycle only; otherwise 0.
- Writes to different registers in the same cycle all complete.

Read:
- port_rdata[p] = reg[addr] combinationally when port_en[p] & port_re[p] and addr < DEPTH; otherwise all zeros.
- Read during a write to the same register returns the old value (the macro below changes this).
- Read and write on the same port in the same cycle are legal.

Counter (register 0):
- Priority order: reset > port write to reg 0 > count.
- cnt_inc & !cnt_dec: reg0 <= reg0 + 1 (mod 2^WIDTH).
- cnt_dec & !cnt_inc: reg0 <= reg0 - 1 (mod 2^WIDTH).
- Both or neither asserted: reg0 holds.
- cnt_co=1 for exactly the one cycle after an increment from all-ones to 0, or a decrement from 0 to all-ones; else 0.
- A port write to reg 0 suppresses counting that cycle, and cnt_co=0 next cycle.

Compare:
- eq is purely combinational from current register state; no latency beyond the register update.

Optional Feature:
MPRAM_BYPASS_EN
- Defined: write-through forwarding. A read hitting a register being written this cycle returns the winning port's port_wdata. A read of reg 0 during counting still returns the pre-count value.
- Undefined: read-before-write; reads always return the stored value.
- Counter, conflict and eq behaviour are identical in both builds.

Test Plan:
- Reset, then read all 4 registers on port 0 -> rdata=0 each; eq=1; cnt_co=0; wr_conflict=0.
- Port 1 writes 4'hA to reg 2; next cycle port 3 reads reg 2 -> 4'hA. Same-cycle read of reg 2 on port 0 -> 0 without MPRAM_BYPASS_EN, 4'hA with it.
- Ports 0 and 2 both write reg 1 (4'h3 and 4'h5) -> reg1=4'h3; wr_conflict=1 for one cycle, then 0.
- Write reg0=4'hE; cnt_inc held 3 cycles -> reg0 4'hF, 4'h0, 4'h1; cnt_co=1 only in the cycle after 4'hF->4'h0. Then cnt_dec from 4'h0 -> 4'hF with cnt_co pulse.
- cnt_inc=1 while port 0 writes reg0=4'h7 -> reg0=4'h7, no increment, cnt_co=0. Then write reg3=4'h7 -> eq=1; write reg3=4'h6 -> eq=0.
- Mid-count reset: cnt_inc=1, reg0=4'h5, port 1 writing reg 2 in the reset cycle -> all registers 0, cnt_co=0 next cycle. Port read with port_en=0 -> rdata=0.
